// File: rtl/lpm_div_seq_pkg.sv
// Shared types and helpers for the lpm_div_seq sequential divider.
package lpm_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  localparam string REP_UNSIGNED = "UNSIGNED";
  localparam string REP_SIGNED   = "SIGNED";

  localparam int unsigned ABS_W = 64;

  // Two's-complement magnitude of the low 'width' bits of value.
  function automatic logic [ABS_W-1:0] abs_twos(input logic [ABS_W-1:0] value,
                                                input int unsigned      width);
    logic [ABS_W-1:0] mask;
    logic [ABS_W-1:0] v;
    mask = (width >= ABS_W) ? '1 : ((ABS_W'(1) << width) - ABS_W'(1));
    v    = value & mask;
    if (width != 0 && ((v >> (width - 1)) & ABS_W'(1)) != '0) begin
      v = (~v + ABS_W'(1)) & mask;
    end
    return v;
  endfunction

endpackage

// File: rtl/lpm_div_seq_if.sv
// Start/done request bus of lpm_div_seq; overflow exists only when DIVIDE_OVF_EN is defined.
interface lpm_div_seq_if #(
  parameter int unsigned WN = 8,
  parameter int unsigned WD = 8
);
  logic          start;
  logic [WN-1:0] numer;
  logic [WD-1:0] denom;
  logic          busy;
  logic          done;
  logic [WN-1:0] quotient;
  logic [WD-1:0] remain;
  logic          div_by_zero;
`ifdef DIVIDE_OVF_EN
  logic          overflow;

  modport master (output start, numer, denom,
                  input  busy, done, quotient, remain, div_by_zero, overflow);
  modport slave  (input  start, numer, denom,
                  output busy, done, quotient, remain, div_by_zero, overflow);
`else
  modport master (output start, numer, denom,
                  input  busy, done, quotient, remain, div_by_zero);
  modport slave  (input  start, numer, denom,
                  output busy, done, quotient, remain, div_by_zero);
`endif
endinterface

// File: rtl/lpm_div_seq_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int unsigned WD = 8
) (
  input  logic [WD:0]   p,
  input  logic          bit_in,
  input  logic [WD-1:0] dmag,
  output logic [WD:0]   p_next,
  output logic          q_bit
);
  localparam int unsigned TW = WD + 2;
  localparam int unsigned PW = WD + 1;

  logic [TW-1:0] t;
  logic [TW-1:0] diff;

  assign t      = {p, bit_in};
  assign diff   = t - TW'(dmag);
  assign q_bit  = (t >= TW'(dmag));
  assign p_next = q_bit ? PW'(diff) : PW'(t);
endmodule

// File: rtl/lpm_div_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Optional DIVIDE_OVF_EN adds an overflow flag and saturates the signed-overflow quotient.
module lpm_div_seq #(
  parameter int unsigned lpm_widthn         = 8,
  parameter int unsigned lpm_widthd         = 8,
  parameter string       lpm_representation = "UNSIGNED"
) (
  input  logic        clk,
  input  logic        rst_n,
  lpm_div_seq_if.slave bus
);
  import lpm_div_pkg::*;

  localparam int unsigned WN = lpm_widthn;
  localparam int unsigned WD = lpm_widthd;
  localparam int unsigned CW = (WN > 1) ? $clog2(WN) : 1;
  localparam bit IS_SIGNED = (lpm_representation == REP_SIGNED);
  localparam bit REP_OK    = IS_SIGNED || (lpm_representation == REP_UNSIGNED);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [WN-1:0] dvd;
  logic [WD:0]   p;
  logic [WD-1:0] dmag;
  logic [WD-1:0] nraw;
  logic          sign_n;
  logic          sign_d;
  logic          dz;

  logic [WN-1:0] nmag_c;
  logic [WD-1:0] dmag_c;
  logic [WD:0]   p_next;
  logic          q_bit;
  logic [WN-1:0] q_fix;
  logic [WD-1:0] r_fix;

  logic          busy_r;
  logic          done_r;
  logic          dz_r;
  logic [WN-1:0] q_r;
  logic [WD-1:0] r_r;
`ifdef DIVIDE_OVF_EN
  logic          ovf_c;
  logic          ovf_r;
`endif

  assign nmag_c = IS_SIGNED ? WN'(abs_twos(ABS_W'(bus.numer), WN)) : bus.numer;
  assign dmag_c = IS_SIGNED ? WD'(abs_twos(ABS_W'(bus.denom), WD)) : bus.denom;

  div_step #(.WD(WD)) u_step (
    .p      (p),
    .bit_in (dvd[WN-1]),
    .dmag   (dmag),
    .p_next (p_next),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (cnt == CW'(WN - 1)) state_next = SIGN;
      SIGN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sign fix-up of the finished magnitudes; divide-by-zero bypasses it.
  always_comb begin
    q_fix = dvd;
    r_fix = p[WD-1:0];
`ifdef DIVIDE_OVF_EN
    ovf_c = 1'b0;
`endif
    if (dz) begin
      q_fix = '1;
      r_fix = nraw;
`ifdef DIVIDE_OVF_EN
      ovf_c = 1'b1;
`endif
    end else begin
      if (sign_n ^ sign_d) q_fix = WN'(0) - dvd;
      if (sign_n)          r_fix = WD'(0) - p[WD-1:0];
`ifdef DIVIDE_OVF_EN
      if (IS_SIGNED && !(sign_n ^ sign_d) && dvd[WN-1]) begin
        ovf_c = 1'b1;
        q_fix = {1'b0, {(WN-1){1'b1}}};
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      dvd    <= '0;
      p      <= '0;
      dmag   <= '0;
      nraw   <= '0;
      sign_n <= 1'b0;
      sign_d <= 1'b0;
      dz     <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      q_r    <= '0;
      r_r    <= '0;
`ifdef DIVIDE_OVF_EN
      ovf_r  <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          dvd    <= nmag_c;
          dmag   <= dmag_c;
          nraw   <= bus.numer[WD-1:0];
          sign_n <= IS_SIGNED & bus.numer[WN-1];
          sign_d <= IS_SIGNED & bus.denom[WD-1];
          dz     <= (bus.denom == '0);
          p      <= '0;
          cnt    <= '0;
          busy_r <= 1'b1;
        end
        // Quotient bits shift into the dividend register as its bits are consumed.
        CALC: begin
          p   <= p_next;
          dvd <= {dvd[WN-2:0], q_bit};
          cnt <= cnt + CW'(1);
        end
        SIGN: begin
          q_r    <= q_fix;
          r_r    <= r_fix;
          dz_r   <= dz;
          busy_r <= 1'b0;
          done_r <= 1'b1;
`ifdef DIVIDE_OVF_EN
          ovf_r  <= ovf_c;
`endif
        end
        default: ;
      endcase
    end
  end

  // An unsupported representation string poisons every output.
  assign bus.busy        = REP_OK ? busy_r : 1'bx;
  assign bus.done        = REP_OK ? done_r : 1'bx;
  assign bus.div_by_zero = REP_OK ? dz_r   : 1'bx;
  assign bus.quotient    = REP_OK ? q_r    : 'x;
  assign bus.remain      = REP_OK ? r_r    : 'x;
`ifdef DIVIDE_OVF_EN
  assign bus.overflow    = REP_OK ? ovf_r  : 1'bx;
`endif

endmodule
